// File: rtl/lsu.sv
// lsu: RV32 load/store unit on a word-wide req/ack bus; optional REQ timeout with LSU_TIMEOUT_EN.
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t st, st_n;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, ld;
  logic [15:0] sh;
  logic [1:0]  off;
  logic        legal_f, ill, to;
  assign off = addr_q[1:0];
  assign legal_f = is_store ? (!funct3[2] && funct3[1:0] != 2'b11) : (funct3[1:0] != 2'b11 && funct3 != 3'd6);
  assign ill = !legal_f || (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && |addr[1:0]);
  assign sh = 16'(mem_rdata >> {off, 3'b000});
  assign ld = f3_q == 3'd0 ? {{24{sh[7]}}, sh[7:0]} :
              f3_q == 3'd1 ? {{16{sh[15]}}, sh[15:0]} :
              f3_q == 3'd4 ? {24'b0, sh[7:0]} :
              f3_q == 3'd5 ? {16'b0, sh[15:0]} : mem_rdata;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // cnt holds the ack-less REQ cycles before the current one
  assign to = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst || st != REQ) cnt <= '0;
    else if (!mem_ack) cnt <= cnt + CW'(1);
`else
  logic unused_to;
  assign to = 1'b0;
  assign unused_to = |TIMEOUT_CYCLES;
`endif
  always_comb begin
    st_n = st == IDLE ? (start ? (ill ? DONE : REQ) : IDLE) :
           st == REQ  ? ((mem_ack || to) ? DONE : REQ) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      st      <= IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      fault   <= 1'b0;
    end else begin
      st <= st_n;
      if (st == IDLE && start) begin
        store_q <= is_store;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (st_n == DONE) begin
        rdata <= (st == REQ && mem_ack && !store_q) ? ld : '0;
        fault <= st == IDLE || !mem_ack;
      end
    end
  assign busy      = st != IDLE;
  assign done      = st == DONE;
  assign mem_req   = st == REQ;
  assign mem_we    = mem_req && store_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wstrb = mem_we ? (f3_q[1] ? 4'hf : (f3_q[0] ? 4'b0011 : 4'b0001) << off) : '0;
  assign mem_wdata = mem_we ? (f3_q[1] ? wdata_q :
                     (f3_q[0] ? {16'b0, wdata_q[15:0]} : {24'b0, wdata_q[7:0]}) << {off, 3'b000}) : '0;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the RV32 core's execute stage. It consumes an effective address, store data and `funct3` from a load (opcode 0000011) or store (opcode 0100011) instruction. It performs one aligned access on a word-wide request/acknowledge data-memory bus and returns the sign- or zero-extended load result that the core writes to `rd`. The core holds the instruction while `busy` is high.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of `REQ` cycles without `mem_ack` before the access is aborted. Only used with `LSU_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: access request, sampled in `IDLE` only.
- `is_store` input 1: 1 = store, 0 = load.
- `funct3` input 3: width/extension code. Load: 0 = LB, 1 = LH, 2 = LW, 4 = LBU, 5 = LHU. Store: 0 = SB, 1 = SH, 2 = SW.
- `addr` input 32: effective byte address.
- `wdata` input 32: store data (`rs2`), right-aligned.
- `busy` output 1: high whenever the state is not `IDLE`.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 32: extended load result. Registered and held until the next `done`.
- `fault` output 1: valid with `done`. Set for a misaligned access, an illegal `funct3`, or a timeout.
- `mem_req` output 1: bus request, high throughout `REQ`.
- `mem_we` output 1: bus write enable.
- `mem_addr` output 32: word address, `{addr[31:2], 2'b00}`.
- `mem_wdata` output 32: store data shifted to the byte lane.
- `mem_wstrb` output 4: byte strobes; 0 for loads.
- `mem_ack` input 1: bus completion, sampled in `REQ` only.
- `mem_rdata` input 32: read word, valid in the same cycle as `mem_ack`.

## Operation
- FSM states are `IDLE`, `REQ` and `DONE`.
- **`IDLE`, `start` = 1:**
  - Latch `is_store`, `funct3`, `addr` and `wdata`.
  - If the access is illegal, go to `DONE` with `fault` = 1 and issue no bus request.
  - Otherwise go to `REQ`.
- **Illegal access:**
  - Any `funct3` outside the tables above.
  - Halfword access (LH, LHU, SH) with `addr[0]` = 1.
  - Word access (LW, SW) with `addr[1:0]` ≠ 0.
- **`REQ`:**
  - `mem_req` = 1, and all `mem_*` outputs are driven from the latched values.
  - On `mem_ack` = 1 go to `DONE`. For a load, `rdata` is captured from `mem_rdata` on that same edge.
- **`DONE`:** `done` = 1 for exactly one cycle, then return to `IDLE`.
- **Lane offset:** `off` = `addr[1:0]`.
- **Store lanes:**
  - SB: `mem_wstrb` = 0001 << `off`; `mem_wdata` = `{24'b0, wdata[7:0]}` << (8·`off`).
  - SH: `mem_wstrb` = 0011 << `off`; `mem_wdata` = `{16'b0, wdata[15:0]}` << (8·`off`).
  - SW: `mem_wstrb` = 1111; `mem_wdata` = `wdata`.
  - `mem_we` = 1.
- **Load extraction:**
  - The selected byte/halfword is `mem_rdata` >> (8·`off`).
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW passes the word through unchanged.
- **`rdata` update rules:**
  - Store completion, fault or timeout sets `rdata` = 0.
  - `rdata` changes only on the edge that enters `DONE`.
- **Ignored inputs:**
  - `start` while `busy` is high.
  - `mem_ack` outside `REQ`.

## Timing
- **Reset:** `rst` = 1 at an edge forces `IDLE`, zeroes the timeout counter and clears `rdata`, `done` and `fault`.
  - After that edge all outputs are 0, and `mem_addr`, `mem_wdata` and `mem_wstrb` read as 0.
  - Reset during `REQ` aborts the access. `mem_req` is low in the cycle after the reset edge, and no `done` is produced.
  - `rst` has priority over `start` and `mem_ack` in the same cycle.
- **Legal access latency:**
  - `start` sampled at edge E0.
  - `mem_req` is high from E0 to the edge where `mem_ack` is sampled, E0+k with k ≥ 1.
  - `done` is high from E0+k to E0+k+1.
  - Minimum latency, with `mem_ack` already high in the first `REQ` cycle, is `done` 2 cycles after `start`.
- **Illegal access latency:** `done` = 1 with `fault` = 1 in the cycle after `start` (1-cycle latency), and `mem_req` never rises.
- **Back-to-back:** a new `start` is accepted in the cycle after `done`, since `IDLE` follows `DONE`. Maximum throughput is one access per 3 cycles.
- **Output types:**
  - `mem_*` outputs are combinational from registered state only, with no combinational path from `mem_ack` or `mem_rdata`.
  - `done` and `busy` are decoded from the state.

## Configuration
- **`LSU_TIMEOUT_EN` defined:**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to `REQ` and increments each `REQ` cycle without `mem_ack`.
  - When `REQ` has lasted `TIMEOUT_CYCLES` cycles without `mem_ack`, go to `DONE` with `fault` = 1 and `rdata` = 0. `mem_req` drops on that edge.
  - If `mem_ack` arrives on the same edge as the timeout, the ack wins: normal completion, `fault` = 0.
- **`LSU_TIMEOUT_EN` undefined:** no counter is synthesized and `REQ` waits indefinitely. `TIMEOUT_CYCLES` is unused.

## Test plan
- **LB sign-extend:** `addr` = 0x8000_0003, `funct3` = 0, `mem_rdata` = 0x8012_3456, ack in the first `REQ` cycle → `mem_addr` = 0x8000_0000, `rdata` = 0xFFFF_FF80, `fault` = 0, `done` exactly 2 cycles after `start`.
- **LHU zero-extend:** `addr` = 0x8000_0002, `mem_rdata` = 0xBEEF_1234, ack 3 cycles late → `rdata` = 0x0000_BEEF, `mem_req` high for 4 cycles, `done` 5 cycles after `start`.
- **SB store lanes:** `addr` = 0x8000_0101, `wdata` = 0x1122_33AB → `mem_we` = 1, `mem_wstrb` = 0010, `mem_wdata` = 0x0000_AB00; `rdata` = 0 at `done`.
- **Misaligned SW:** `addr` = 0x8000_0002 → no `mem_req`, `done` = 1 and `fault` = 1 the next cycle. Same check for `funct3` = 3 on a load.
- **Reset mid-access:** `rst` pulsed during `REQ` while `mem_ack` is held low → `mem_req` = 0 and `busy` = 0 after the edge, no `done`. A following LW completes normally.
- **Timeout, `LSU_TIMEOUT_EN` with `TIMEOUT_CYCLES` = 4:** no ack → `done` with `fault` = 1 and `rdata` = 0 after 4 `REQ` cycles. A second access with ack in the 4th `REQ` cycle completes with `fault` = 0.
